ram_dp_bus: RTL and testbench

- Parametrised dual-port on-chip RAM for the vm1801mini system.
- Port A is the CPU port: a byte-lane, read/write, request/acknowledge bus slave with configurable wait states.
- Port B is a read-only port for the video/character-generator fetcher.
- Optional clear sequencer zeroes the whole array after reset. Maps onto block RAM.

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_tdp_core.sv | 48 ++++
 rtl/ram_dp_bus.sv | 164 ++++++++++++++++
 tb/tb_ram_dp_bus.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port bus RAM.
// FSM state enum, lane-count helper and wait-counter width.
package ram_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_e;

  localparam int WCNT_W = 4;

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/ram_tdp_core.sv
// Inferred dual-port memory: byte-lane write-first port A,
// read-only port B (old data on collision). No reset.
module ram_tdp_core
  import ram_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 10,
  localparam int LANES  = lanes(DATA_W)
) (
  input  logic              clk_i,
  input  logic              a_en_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [LANES-1:0]  a_sel_i,
  input  logic [DATA_W-1:0] a_di_i,
  output logic [DATA_W-1:0] a_do_o,
  input  logic              b_en_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  output logic [DATA_W-1:0] b_do_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] a_do_q;
  logic [DATA_W-1:0] b_do_q;

  always_ff @(posedge clk_i) begin
    if (a_en_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (a_we_i && a_sel_i[i]) begin
          mem_q[a_addr_i][i*8 +: 8] <= a_di_i[i*8 +: 8];
          a_do_q[i*8 +: 8] <= a_di_i[i*8 +: 8];
        end else begin
          a_do_q[i*8 +: 8] <= mem_q[a_addr_i][i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (b_en_i) begin
      b_do_q <= mem_q[b_addr_i];
    end
  end

  assign a_do_o = a_do_q;
  assign b_do_o = b_do_q;

endmodule

// File: rtl/ram_dp_bus.sv
// Dual-port RAM with req/ack CPU port A, read-only port B,
// wait states and optional clear-after-reset sequencer.
module ram_dp_bus
  import ram_pkg::*;
#(
  parameter  int DATA_W         = 16,
  parameter  int ADDR_W         = 10,
  parameter  int WAIT_STATES    = 0,
  parameter  int CLEAR_ON_RESET = 0,
  localparam int LANES          = lanes(DATA_W)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              A_REQ,
  input  logic              A_WR,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [LANES-1:0]  A_SEL,
  input  logic [DATA_W-1:0] A_DI,
  output logic [DATA_W-1:0] A_DO,
  output logic              A_ACK,
  input  logic              B_EN,
  input  logic [ADDR_W-1:0] B_ADDR,
  output logic [DATA_W-1:0] B_DO,
  output logic              B_VLD,
  output logic              BUSY
);

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LANES-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   di_q, di_d;
  logic [DATA_W-1:0]   a_do_q;
  logic [DATA_W-1:0]   b_do_q;
  logic                b_vld_q;

  logic                m_en;
  logic                m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [LANES-1:0]    m_sel;
  logic [DATA_W-1:0]   m_di;
  logic [DATA_W-1:0]   core_ado;
  logic [DATA_W-1:0]   core_bdo;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    clr_d   = clr_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    di_d    = di_q;
    m_en    = 1'b0;
    m_we    = wr_q;
    m_addr  = addr_q;
    m_sel   = sel_q;
    m_di    = di_q;
    unique case (state_q)
      ST_CLEAR: begin
        m_en   = 1'b1;
        m_we   = 1'b1;
        m_addr = clr_q;
        m_sel  = '1;
        m_di   = '0;
        clr_d  = clr_q + 1'b1;
        if (clr_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (A_REQ) begin
          wr_d   = A_WR;
          addr_d = A_ADDR;
          sel_d  = A_SEL;
          di_d   = A_DI;
          if (WAIT_STATES == 0) begin
            // zero wait: access on the acceptance edge
            m_en    = 1'b1;
            m_we    = A_WR;
            m_addr  = A_ADDR;
            m_sel   = A_SEL;
            m_di    = A_DI;
            state_d = ST_ACK;
          end else begin
            wcnt_d  = WCNT_W'(WAIT_STATES - 1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          m_en    = 1'b1;
          state_d = ST_ACK;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      wcnt_q  <= '0;
      clr_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      di_q    <= '0;
      a_do_q  <= '0;
      b_do_q  <= '0;
      b_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      clr_q   <= clr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      di_q    <= di_d;
      b_vld_q <= B_EN;
      if (state_q == ST_ACK) begin
        a_do_q <= core_ado;
      end
      if (b_vld_q) begin
        b_do_q <= core_bdo;
      end
    end
  end

  // reset edge must never commit a write
  ram_tdp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk_i    (CLK),
    .a_en_i   (m_en & RST_N),
    .a_we_i   (m_we),
    .a_addr_i (m_addr),
    .a_sel_i  (m_sel),
    .a_di_i   (m_di),
    .a_do_o   (core_ado),
    .b_en_i   (B_EN),
    .b_addr_i (B_ADDR),
    .b_do_o   (core_bdo)
  );

  // core outputs are live in the valid cycle,
  // shadow registers hold them afterwards
  assign A_ACK = (state_q == ST_ACK);
  assign A_DO  = A_ACK ? core_ado : a_do_q;
  assign B_VLD = b_vld_q;
  assign B_DO  = b_vld_q ? core_bdo : b_do_q;
  assign BUSY  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_dp_bus.sv
// Bench for ram_dp_bus: three instances (0/3/1 wait states,
// the last with clear-on-reset) against an array model.
module tb_ram_dp_bus;

  logic        clk;
  logic        rst_n [3];
  logic        req   [3];
  logic        wr    [3];
  logic [3:0]  addr  [3];
  logic [1:0]  sel   [3];
  logic [15:0] di    [3];
  logic [15:0] ado   [3];
  logic        ack   [3];
  logic        ben   [3];
  logic [3:0]  baddr [3];
  logic [15:0] bdo   [3];
  logic        bvld  [3];
  logic        busy  [3];

  logic [15:0] mdl [3][16];
  int          wsv [3] = '{0, 3, 1};
  int          n_chk = 0;
  int          n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_dp_bus #(
      .DATA_W         (16),
      .ADDR_W         (4),
      .WAIT_STATES    (g == 1 ? 3 : (g == 2 ? 1 : 0)),
      .CLEAR_ON_RESET (g == 2 ? 1 : 0)
    ) u_dut (
      .CLK    (clk),
      .RST_N  (rst_n[g]),
      .A_REQ  (req[g]),
      .A_WR   (wr[g]),
      .A_ADDR (addr[g]),
      .A_SEL  (sel[g]),
      .A_DI   (di[g]),
      .A_DO   (ado[g]),
      .A_ACK  (ack[g]),
      .B_EN   (ben[g]),
      .B_ADDR (baddr[g]),
      .B_DO   (bdo[g]),
      .B_VLD  (bvld[g]),
      .BUSY   (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [15:0] d,
                                        input logic [1:0] s);
    logic [15:0] r;
    r = old;
    if (s[0]) r[7:0]  = d[7:0];
    if (s[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // one full port-A transaction; DUT is assumed idle
  task automatic acc(input int k, input logic w, input logic [3:0] a,
                     input logic [1:0] s, input logic [15:0] d);
    logic [15:0] exp;
    int lat;
    exp = w ? merge(mdl[k][a], d, s) : mdl[k][a];
    if (w) mdl[k][a] = exp;
    req[k] = 1'b1; wr[k] = w; addr[k] = a; sel[k] = s; di[k] = d;
    lat = 0;
    do begin
      tick();
      lat++;
      // inputs only matter at acceptance
      addr[k] = 4'($urandom); di[k] = 16'($urandom);
      sel[k] = 2'($urandom);
    end while (!ack[k] && lat < 40);
    req[k] = 1'b0; wr[k] = 1'b0;
    chk("a_latency", lat, wsv[k] + 1);
    chk("a_do", ado[k], exp);
    tick();
    chk("a_ack_pulse", ack[k], 0);
    chk("a_do_hold", ado[k], exp);
  endtask

  task automatic bread(input int k, input logic [3:0] a);
    ben[k] = 1'b1; baddr[k] = a;
    tick();
    ben[k] = 1'b0; baddr[k] = 4'($urandom);
    chk("b_vld", bvld[k], 1);
    chk("b_do", bdo[k], mdl[k][a]);
    tick();
    chk("b_vld_low", bvld[k], 0);
    chk("b_do_hold", bdo[k], mdl[k][a]);
  endtask

  initial begin
    int cnt;
    int n1;
    int n2;
    logic seen;
    logic [15:0] v;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0;
      sel[k] = '0; di[k] = '0; ben[k] = 1'b0; baddr[k] = '0;
      for (int a = 0; a < 16; a++) mdl[k][a] = '0;
    end

    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_ack", ack[k], 0);
      chk("rst_ado", ado[k], 0);
      chk("rst_bdo", bdo[k], 0);
      chk("rst_bvld", bvld[k], 0);
      chk("rst_busy", busy[k], k == 2);
    end
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

    cnt = 0;
    while (busy[2] && cnt < 40) begin tick(); cnt++; end
    chk("clear_len0", cnt, 16);

    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 16; a++)
        acc(k, 1'b1, 4'(a), 2'b11, 16'($urandom) | 16'h0101);

    // directed, zero wait states
    acc(0, 1'b1, 4'd5, 2'b11, 16'h1234);
    acc(0, 1'b0, 4'd5, 2'b00, 16'h0);
    acc(0, 1'b1, 4'd5, 2'b01, 16'hABCD);
    chk("lane_model", mdl[0][5], 16'h12CD);
    bread(0, 4'd5);
    acc(0, 1'b1, 4'd6, 2'b00, 16'hFFFF);

    // collision: write edge coincides with B read
    acc(0, 1'b1, 4'd9, 2'b11, 16'h0001);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 4'd9;
    sel[0] = 2'b11; di[0] = 16'h00FF;
    ben[0] = 1'b1; baddr[0] = 4'd9;
    tick();
    req[0] = 1'b0; wr[0] = 1'b0; ben[0] = 1'b0;
    chk("col_ack", ack[0], 1);
    chk("col_ado", ado[0], 16'h00FF);
    chk("col_bvld", bvld[0], 1);
    chk("col_bdo_old", bdo[0], 16'h0001);
    mdl[0][9] = 16'h00FF;
    tick();
    chk("col_ack_low", ack[0], 0);
    bread(0, 4'd9);

    // three wait states, back-to-back reads
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 4'd2;
    n1 = 0;
    do begin tick(); n1++; end while (!ack[1] && n1 < 40);
    chk("ws3_lat", n1, 4);
    chk("ws3_do1", ado[1], mdl[1][2]);
    addr[1] = 4'd11;
    n2 = 0;
    do begin tick(); n2++; end while (!ack[1] && n2 < 40);
    req[1] = 1'b0;
    chk("ws3_period", n2, 5);
    chk("ws3_do2", ado[1], mdl[1][11]);
    tick();
    chk("ws3_ack_low", ack[1], 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int k;
      k = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0)
        bread(k, 4'($urandom));
      else
        acc(k, 1'($urandom), 4'($urandom), 2'($urandom),
            16'($urandom));
    end

    // reset during WAIT of a write
    acc(1, 1'b1, 4'd7, 2'b11, 16'h5A5A);
    bread(1, 4'd7);
    v = mdl[1][7];
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 4'd7;
    sel[1] = 2'b11; di[1] = ~v;
    tick();
    tick();
    rst_n[1] = 1'b0; req[1] = 1'b0; wr[1] = 1'b0;
    tick();
    chk("mw_ack", ack[1], 0);
    chk("mw_ado", ado[1], 0);
    chk("mw_bdo", bdo[1], 0);
    chk("mw_bvld", bvld[1], 0);
    chk("mw_busy", busy[1], 0);
    rst_n[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack[1]) seen = 1'b1;
    end
    chk("mw_no_ack", seen, 0);
    acc(1, 1'b0, 4'd7, 2'b00, 16'h0);
    chk("mw_word_kept", mdl[1][7], 16'h5A5A);

    // clear after reset pulse, request held during clear
    rst_n[2] = 1'b0;
    tick();
    chk("clr_busy_rst", busy[2], 1);
    rst_n[2] = 1'b1;
    req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 4'd3;
    cnt = 0;
    seen = 1'b0;
    while (busy[2] && cnt < 40) begin
      tick();
      cnt++;
      if (ack[2]) seen = 1'b1;
    end
    chk("clr_len", cnt, 16);
    chk("clr_no_ack", seen, 0);
    n1 = 0;
    do begin tick(); n1++; end while (!ack[2] && n1 < 40);
    req[2] = 1'b0;
    chk("clr_pend_lat", n1, 2);
    chk("clr_pend_do", ado[2], 0);
    tick();
    for (int a = 0; a < 16; a++) mdl[2][a] = '0;
    for (int a = 0; a < 16; a++) acc(2, 1'b0, 4'(a), 2'b11, 16'h0);
    bread(2, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
